// File: rtl/muldiv_iter.sv
// Shared iterative multiply/divide engine: signed/unsigned shift-add multiply and restoring divide.
// Define MUL_FAST_EN to replace the iterative multiply with a single-cycle product.
module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic [1:0]         op_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               div_by_zero_o,
   output logic               stallreq_o
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam int W2 = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, CALC, DZERO, DONE} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
   logic              is_div_q, is_div_d, negq_q, negq_d, negr_q, negr_d;
   logic [W2-1:0]     result_q, result_d;
   logic              dz_q, dz_d;
   logic              accept, dz_start, sgn;
   logic [WIDTH:0]    mul_sum, div_shift;
   logic [WIDTH-1:0]  div_diff, step_hi, step_lo;
   logic              div_ge;
   logic [W2-1:0]     res_fin;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
      return (s && x[WIDTH-1]) ? -x : x;
   endfunction

   function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] x, input logic n);
      return n ? -x : x;
   endfunction

   function automatic logic [W2-1:0] cneg2(input logic [W2-1:0] x, input logic n);
      return n ? -x : x;
   endfunction

   assign sgn      = ~op_i[0];
   assign accept   = (state_q == IDLE) && start_i && !annul_i;
   assign dz_start = accept && op_i[1] && (opdata2_i == '0);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (accept) state_d = dz_start ? DZERO : CALC;
         CALC: begin
            if (annul_i) state_d = IDLE;
`ifdef MUL_FAST_EN
            else if (!is_div_q) state_d = DONE;
`endif
            else if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
         end
         DZERO: state_d = annul_i ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready_o       = (state_q == DONE);
      div_by_zero_o = (state_q == DONE) && dz_q;
      stallreq_o    = accept || (state_q == CALC) || (state_q == DZERO);
   end

   assign result_o = result_q;

   // One shift-add (mul) or restoring shift-subtract (div) step on {hi, lo}.
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
      div_shift = {hi_q, lo_q[WIDTH-1]};
      div_ge    = div_shift >= {1'b0, opb_q};
      div_diff  = div_shift[WIDTH-1:0] - opb_q;
      if (is_div_q) begin
         step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
         step_lo = {lo_q[WIDTH-2:0], div_ge};
      end else begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
      if (is_div_q)
         res_fin = {cneg(step_hi, negr_q), cneg(step_lo, negq_q)};
      else
`ifdef MUL_FAST_EN
         res_fin = cneg2(W2'(opb_q) * W2'(lo_q), negq_q);
`else
         res_fin = cneg2({step_hi, step_lo}, negq_q);
`endif
   end

   always_comb begin
      hi_d     = hi_q;
      lo_d     = lo_q;
      opb_d    = opb_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      result_d = result_q;
      dz_d     = dz_q;
      if (accept) begin
         cnt_d    = '0;
         hi_d     = '0;
         is_div_d = op_i[1];
         negq_d   = sgn && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
         negr_d   = sgn && opdata1_i[WIDTH-1];
         // Divide: lo holds the dividend (raw when the divisor is zero), opb the divisor.
         // Multiply: lo holds the multiplier, opb the multiplicand.
         if (op_i[1]) begin
            lo_d  = dz_start ? opdata1_i : mag(opdata1_i, sgn);
            opb_d = mag(opdata2_i, sgn);
         end else begin
            lo_d  = mag(opdata2_i, sgn);
            opb_d = mag(opdata1_i, sgn);
         end
      end else if (state_q == CALC) begin
         hi_d  = step_hi;
         lo_d  = step_lo;
         cnt_d = cnt_q + CW'(1);
      end
      if (state_q == CALC && state_d == DONE) begin
         result_d = res_fin;
         dz_d     = 1'b0;
      end
      if (state_q == DZERO && state_d == DONE) begin
         result_d = {lo_q, {WIDTH{1'b1}}};
         dz_d     = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         result_q <= '0;
         dz_q     <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         result_q <= result_d;
         dz_q     <= dz_d;
      end
   end

   always_ff @(posedge clk) begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
   end
endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Parametrised iterative multiply/divide unit for the EX stage. It replaces the separate fixed-width `mul`/`div` pair with one shared engine for signed and unsigned multiply and divide. It uses a start/ready handshake and raises a stall request while busy. EX holds `start_i` and the operands stable until `ready_o`, then advances.

## Interface
- `WIDTH`, default 32: operand width. Must be even and ≥ 4. Results are `2*WIDTH` wide.
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start_i`, input, 1: request. Sampled only in IDLE.
- `op_i`, input, 2: `00` mul signed, `01` mul unsigned, `10` div signed, `11` div unsigned.
- `opdata1_i`, input, WIDTH: multiplicand or dividend.
- `opdata2_i`, input, WIDTH: multiplier or divisor.
- `annul_i`, input, 1: abort the current operation (flush).
- `result_o`, output, 2*WIDTH:
  - mul: full product {hi, lo}.
  - div: {remainder, quotient}.
- `ready_o`, output, 1: result valid. High for exactly one cycle.
- `div_by_zero_o`, output, 1: qualifies `ready_o` for div ops with a zero divisor.
- `stallreq_o`, output, 1: pipeline stall request.

## Operation
- FSM states:
  - IDLE:
    - `start_i & ~annul_i` → latch op and operand magnitudes, clear the counter, go to CALC.
    - A div op with `opdata2_i == 0` goes to DZERO instead.
  - CALC:
    - Div: one restoring shift-subtract step per cycle.
    - Mul: one shift-add step per cycle.
    - When the counter reaches WIDTH-1, go to DONE.
    - `annul_i` → IDLE.
  - DZERO: load the divide-by-zero result, go to DONE.
  - DONE: `ready_o=1`, then IDLE unconditionally. `start_i` is ignored in DONE.
- Signed ops:
  - Operands are converted to magnitudes; |−2^(WIDTH−1)| = 2^(WIDTH−1) fits unsigned.
  - Product sign = s1^s2.
  - Quotient sign = s1^s2; remainder sign = s1. Truncation toward zero.
- Overflow: `div` of −2^(WIDTH−1) by −1 wraps to quotient −2^(WIDTH−1), remainder 0. No flag is raised.
- Divide by zero: quotient = all ones, remainder = dividend (raw, unsigned and signed alike). `div_by_zero_o=1` alongside `ready_o`.
- `result_o` is registered. It updates only on entry to DONE and holds until the next DONE.
- `stallreq_o = (IDLE & start_i & ~annul_i) | CALC | DZERO`. It is 0 in DONE, which lets EX advance in the same cycle `ready_o` is high.
- Annul:
  - In CALC or DZERO: return to IDLE next cycle, no `ready_o`, `result_o` unchanged.
  - In IDLE: `annul_i` overrides `start_i`.
  - In DONE: no effect (result still delivered).
- Reset: state IDLE, counter 0. `result_o=0`, `ready_o=0`, `div_by_zero_o=0`, `stallreq_o=0` as long as `start_i=0`.

## Timing
- Start accepted at edge T (IDLE, `start_i=1`).
- Div latency: CALC occupies T+1 … T+WIDTH; `ready_o` is high in cycle T+WIDTH+1. For WIDTH=32, that is 33 cycles after acceptance.
- Div by zero: DZERO at T+1, `ready_o` at T+2.
- Mul latency: same as div without the macro; see Configuration.
- Back-to-back: a new start can be accepted in the cycle after DONE (IDLE). Minimum issue interval is latency+1.
- Counter width is $clog2(WIDTH)+1. It does not wrap within an operation.
- `rst` has priority over every input, including mid-CALC: the unit returns to IDLE on the next edge.

## Configuration
- `MUL_FAST_EN`:
  - Defined: multiply uses a single-cycle `2*WIDTH` signed/unsigned product. CALC lasts one cycle for mul ops, so `ready_o` is high at T+2.
  - Undefined: multiply is iterative (WIDTH CALC cycles, `ready_o` at T+WIDTH+1).
- Divide behaviour and all handshakes are identical in both builds.

## Test plan
- divu, WIDTH=32, 100 / 7 → `ready_o` at T+33, `result_o` = {0x00000002, 0x0000000E}, `stallreq_o` high T…T+32 and low at T+33.
- div, −7 / 2 → {0xFFFFFFFF, 0xFFFFFFFD}. Also div 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}.
- divu 5 / 0 → `ready_o` and `div_by_zero_o` at T+2, `result_o` = {0x00000005, 0xFFFFFFFF}.
- mul signed 0xFFFFFFFF × 2 → 0xFFFFFFFF_FFFFFFFE. mulu with the same operands → 0x00000001_FFFFFFFE. `ready_o` at T+33 without `MUL_FAST_EN`, at T+2 with it.
- divu started, `annul_i` pulsed in CALC cycle 10 → IDLE next cycle, no `ready_o`, `result_o` keeps its previous value. A new start the following cycle completes correctly.
- `rst` asserted mid-CALC → next cycle IDLE, all outputs 0. `start_i` held high through DONE does not retrigger the unit.
